// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
//   sw_state_t  : controller states
//   SEC_MAX     : highest seconds value
//   SEC_W       : seconds field width
//   min_width() : minute field width for a given highest minute value
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } sw_state_t;

  localparam int SEC_MAX = 59;
  localparam int SEC_W   = 6;

  function automatic int min_width(input int min_max);
    return (min_max < 1) ? 1 : $clog2(min_max + 1);
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO for lap captures.
//   clk, reset : clock, async active-high reset
//   flush      : empties the FIFO this cycle (wins over push/pop)
//   push       : write push_data unless full; when full it still
//                succeeds if a pop happens in the same cycle
//   full       : no free entry
//   pop        : consumer ready; an entry leaves when pop && valid
//   valid      : FIFO non-empty
//   head       : oldest entry, zero while empty
module lap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being
  // vacated; the head read this cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch / countdown timer with internal one-second prescaler and a
// lap-capture FIFO drained over a valid/ready handshake.
//   clk, reset          : system clock, async active-high reset
//   start, stop, clear  : front-panel commands (clear > load > start > stop)
//   mode_down           : count direction, latched on start from IDLE
//   load, load_min/sec  : preset time (IDLE or PAUSED), saturated to range
//   lap                 : capture current {min,sec} (RUN or PAUSED)
//   sec, min            : current time
//   running             : high in RUN
//   done                : one-cycle pulse when a down-count reaches 00:00
//   wrap                : one-cycle pulse on up-count MIN_MAX:59 -> 00:00
//   lap_valid/ready/data: lap FIFO head handshake
//   lap_overflow        : sticky, a lap was dropped on a full FIFO
//
// state   | meaning
// IDLE    | stopped, time may be preset, direction chosen on start
// RUN     | prescaler advancing, time stepping once per tick
// PAUSED  | time and prescaler phase frozen, presets and laps allowed
// EXPIRED | down-count finished at 00:00, waits for clear
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter  int TICK_DIV  = 50_000_000,
  parameter  int MIN_MAX   = 59,
  parameter  int LAP_DEPTH = 4,
  localparam int MIN_W     = min_width(MIN_MAX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               mode_down,
  input  logic               load,
  input  logic [MIN_W-1:0]   load_min,
  input  logic [SEC_W-1:0]   load_sec,
  input  logic               lap,
  output logic [SEC_W-1:0]   sec,
  output logic [MIN_W-1:0]   min,
  output logic               running,
  output logic               done,
  output logic               wrap,
  output logic               lap_valid,
  input  logic               lap_ready,
  output logic [MIN_W+SEC_W-1:0] lap_data,
  output logic               lap_overflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [SEC_W-1:0] SEC_TOP    = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] SEC_ONE    = SEC_W'(1);
  localparam logic [MIN_W-1:0] MIN_TOP    = MIN_W'(MIN_MAX);
  localparam logic [MIN_W-1:0] MIN_ONE    = MIN_W'(1);

  sw_state_t        state, state_nxt;
  logic [SEC_W-1:0] sec_q, sec_nxt;
  logic [MIN_W-1:0] min_q, min_nxt;
  logic [PW-1:0]    presc_q, presc_nxt;
  logic             down_q, down_nxt;
  logic             done_q, done_nxt;
  logic             wrap_q, wrap_nxt;
  logic             ovf_q, ovf_nxt;

  logic             tick;
  logic             time_zero;
  logic             sec_at_max, min_at_max;
  logic [SEC_W-1:0] up_sec, dn_sec;
  logic [MIN_W-1:0] up_min, dn_min;
  logic             up_wrap, dn_zero;
  logic [SEC_W-1:0] load_sec_sat;
  logic [MIN_W-1:0] load_min_sat;

  logic             lap_push;
  logic             lap_full;
  logic             fifo_flush;

  assign tick       = (state == RUN) && (presc_q == PRESC_LAST);
  assign time_zero  = (sec_q == '0) && (min_q == '0);
  assign sec_at_max = (sec_q == SEC_TOP);
  assign min_at_max = (min_q == MIN_TOP);

  assign up_sec  = sec_at_max ? '0 : sec_q + SEC_ONE;
  assign up_min  = !sec_at_max ? min_q : (min_at_max ? '0 : min_q + MIN_ONE);
  assign up_wrap = sec_at_max && min_at_max;

  // Borrowing below 00:00 never happens in RUN (start at 00:00 goes straight
  // to EXPIRED), but the borrow still lands on MIN_MAX to stay in range.
  assign dn_sec  = (sec_q == '0) ? SEC_TOP : sec_q - SEC_ONE;
  assign dn_min  = (sec_q != '0) ? min_q : ((min_q == '0) ? MIN_TOP : min_q - MIN_ONE);
  assign dn_zero = (dn_sec == '0) && (dn_min == '0);

  assign load_sec_sat = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;

  // Only clamp minutes when the field can hold values above MIN_MAX.
  generate
    if (MIN_MAX < (1 << MIN_W) - 1) begin : g_min_clamp
      assign load_min_sat = (load_min > MIN_TOP) ? MIN_TOP : load_min;
    end else begin : g_min_full
      assign load_min_sat = load_min;
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    sec_nxt    = sec_q;
    min_nxt    = min_q;
    presc_nxt  = presc_q;
    down_nxt   = down_q;
    done_nxt   = 1'b0;
    wrap_nxt   = 1'b0;
    ovf_nxt    = ovf_q;
    fifo_flush = 1'b0;
    lap_push   = 1'b0;

    if (clear) begin
      state_nxt  = IDLE;
      sec_nxt    = '0;
      min_nxt    = '0;
      presc_nxt  = '0;
      ovf_nxt    = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      // Laps capture the time as it stands before any tick this cycle.
      lap_push = lap && ((state == RUN) || (state == PAUSED));
      if (lap_push && lap_full && !lap_ready) ovf_nxt = 1'b1;

      unique case (state)
        IDLE: begin
          if (load) begin
            sec_nxt = load_sec_sat;
            min_nxt = load_min_sat;
          end else if (start) begin
            presc_nxt = '0;
            down_nxt  = mode_down;
            if (mode_down && time_zero) begin
              state_nxt = EXPIRED;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          presc_nxt = tick ? '0 : presc_q + PRESC_ONE;
          // A tick coinciding with stop is dropped.
          if (stop && !start) begin
            state_nxt = PAUSED;
          end else if (tick) begin
            if (!down_q) begin
              sec_nxt  = up_sec;
              min_nxt  = up_min;
              wrap_nxt = up_wrap;
            end else begin
              sec_nxt = dn_sec;
              min_nxt = dn_min;
              if (dn_zero) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        PAUSED: begin
          if (load) begin
            sec_nxt = load_sec_sat;
            min_nxt = load_min_sat;
          end else if (start) begin
            if (down_q && time_zero) begin
              state_nxt = EXPIRED;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        EXPIRED: begin
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sec_q   <= '0;
      min_q   <= '0;
      presc_q <= '0;
      down_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sec_q   <= sec_nxt;
      min_q   <= min_nxt;
      presc_q <= presc_nxt;
      down_q  <= down_nxt;
      done_q  <= done_nxt;
      wrap_q  <= wrap_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  lap_fifo #(
    .WIDTH (MIN_W + SEC_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (lap_push),
    .push_data ({min_q, sec_q}),
    .full      (lap_full),
    .pop       (lap_ready),
    .valid     (lap_valid),
    .head      (lap_data)
  );

  assign sec          = sec_q;
  assign min          = min_q;
  assign running      = (state == RUN);
  assign done         = done_q;
  assign wrap         = wrap_q;
  assign lap_overflow = ovf_q;

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised successor to the basic seconds/minutes stopwatch. It runs from the fast system clock and uses an internal prescaler instead of a pre-divided clock. It counts up (stopwatch) or down (timer, from a loaded value) and buffers lap captures in a small FIFO that downstream logic drains with a valid/ready handshake. It sits between the front-panel debounced controls and the display/UART readout logic.

Parameters:
TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2)
MIN_MAX, 59, highest minute value before wrap (1..255)
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level/pulse; begin or resume counting
stop  in  1  pause counting
clear  in  1  zero time, flush laps, clear overflow, go IDLE
mode_down  in  1  0 = count up, 1 = count down; sampled only in IDLE
load  in  1  load load_min/load_sec (IDLE or PAUSED only)
load_min  in  MIN_W  minute preset, MIN_W = clog2(MIN_MAX+1)
load_sec  in  6  second preset (values >59 saturate to 59)
lap  in  1  capture current time into lap FIFO
sec  out  6  current seconds 0–59
min  out  MIN_W  current minutes 0–MIN_MAX
running  out  1  high in RUN
done  out  1  1-cycle pulse on down-count reaching 00:00
wrap  out  1  1-cycle pulse on up-count MIN_MAX:59 -> 00:00
lap_valid  out  1  FIFO non-empty
lap_ready  in  1  consumer accepts head entry
lap_data  out  MIN_W+6  {min,sec} at FIFO head
lap_overflow  out  1  sticky: a lap was dropped because FIFO was full

Behaviour:
- Reset (async): sec=0, min=0, prescaler=0, state IDLE, dir latch=up, FIFO empty, all pulses/flags 0.
- States: IDLE, RUN, PAUSED, EXPIRED. Command priority per cycle: clear > load > start > stop.
- IDLE: start -> RUN (latch mode_down); load -> presets written, stay IDLE.
- RUN: stop -> PAUSED; clear -> IDLE; load is ignored.
- PAUSED: start -> RUN; load writes presets; clear -> IDLE.
- EXPIRED: time holds at 00:00; only clear leaves (-> IDLE); start is ignored.
- Start in IDLE with down mode and time 00:00 -> EXPIRED directly, done pulses next cycle, no tick counted.
- Prescaler: advances only in RUN. It holds value in PAUSED, so resume keeps phase. It zeroes on clear and on IDLE->RUN. A tick occurs in the cycle the prescaler equals TICK_DIV-1 (it then returns to 0). The first tick comes TICK_DIV cycles after entering RUN from IDLE.
- Time update is registered. The new value is visible the cycle after the tick.
- Up count: sec 59 -> 0 with min+1; at MIN_MAX:59 -> 00:00 and wrap=1 for one cycle; keep running.
- Down count: sec 0 -> 59 with min-1; the tick that yields 00:00 sets done=1 (one cycle), state -> EXPIRED, running=0 the same cycle done is high.
- stop and tick in the same cycle: the tick is discarded.
- Lap: accepted in RUN or PAUSED, ignored otherwise. It pushes the pre-tick registered {min,sec} for that cycle. If the FIFO is full and no pop happens that cycle, the entry is dropped and lap_overflow is set. Push and pop in the same cycle when full: both succeed.
- Pop: lap_valid && lap_ready. lap_data is the registered head, stable while lap_valid && !lap_ready.
- clear mid-operation flushes the FIFO the same cycle; a simultaneous lap is discarded.
- Widths: all arithmetic is modulo the field width; no out-of-range values are ever stored.

Decomposition:
- Package stopwatch_pkg: state enum (IDLE, RUN, PAUSED, EXPIRED), SEC_MAX=59, SEC_W=6, helper function for MIN_W.
- Sub-module lap_fifo: a synchronous FIFO parametrised by width and depth, with push/full/pop/valid, flush, and simultaneous push+pop when full.

Test Plan:
- TICK_DIV=4, reset, start, wait 20 cycles -> sec=5, min=0, running=1; stop, wait 40 -> sec holds 5.
- MIN_MAX=1, up from 00:00 after 120 ticks -> wrap pulses exactly once, time 00:00, still running.
- Down: load 0:03, mode_down=1, start -> sec 2,1,0 on successive ticks; done pulse with 00:00; state EXPIRED; start ignored; clear -> IDLE.
- Down start at 00:00 -> EXPIRED, done after 1 cycle, time unchanged.
- LAP_DEPTH=4, lap_ready=0, 5 laps at distinct times -> 4 entries kept, lap_overflow=1; drain -> entries in capture order; clear -> overflow 0.
- Assert reset mid-RUN and mid-drain -> all outputs zero immediately, asynchronously; lap_valid=0.
